// File: rtl/uart_tx_param.sv
// uart_tx_param -- parameterised UART transmitter with a TX FIFO.
//
// Characters pushed into the FIFO are serialised LSB first as
// start / 5..9 data bits / optional parity / 1, 1.5 or 2 stop bits.
// Every bit lasts OVS ticks of the one-clk 'enable' strobe. Frame format
// is sampled when the character leaves the FIFO, so configuration changes
// never disturb a frame that is already on the line.
//
// Ports:
//   clk, wb_rst_i   clock and synchronous active-high reset
//   enable          one-clk oversample tick; the FSM only moves on ticks
//   tf_push/tf_data FIFO write strobe and character
//   tx_reset        FIFO flush (pointers, count, overrun)
//   cfg_*           length / parity / stop / break configuration
//   stx_pad_o       serial output (forced low while cfg_bc=1)
//   tstate          FSM state code
//   tf_count/tf_full/tf_overrun  FIFO status
//   tx_empty        FIFO empty and transmitter idle
//   frame_done      one-clk pulse when a stop bit finishes
module uart_tx_param #(
   parameter int DW    = 9,
   parameter int DEPTH = 16,
   parameter int OVS   = 16
) (
   input  logic                     clk,
   input  logic                     wb_rst_i,
   input  logic                     enable,
   input  logic                     tf_push,
   input  logic [DW-1:0]            tf_data,
   input  logic                     tx_reset,
   input  logic [2:0]               cfg_len,
   input  logic                     cfg_pe,
   input  logic                     cfg_ep,
   input  logic                     cfg_sp,
   input  logic                     cfg_stb,
   input  logic                     cfg_bc,
   output logic                     stx_pad_o,
   output logic [2:0]               tstate,
   output logic [$clog2(DEPTH):0]   tf_count,
   output logic                     tf_full,
   output logic                     tf_overrun,
   output logic                     tx_empty,
   output logic                     frame_done
);

   localparam int AW = $clog2(DEPTH);
   // Tick counter must reach 2*OVS-1 for the longest stop period.
   localparam int TW = $clog2(2 * OVS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_POP    = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_PARITY = 3'd4;
   localparam logic [2:0] S_STOP   = 3'd5;

   localparam logic [TW-1:0] OVS_LAST   = TW'(OVS - 1);
   localparam logic [TW-1:0] STOP15_LAST = TW'((3 * OVS) / 2 - 1);
   localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVS - 1);

   // ---------------- FIFO ----------------
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          overrun_reg;

   // ---------------- transmitter ----------------
   logic [2:0]    state_reg;
   logic [TW-1:0] tick_reg;
   logic [3:0]    bit_reg;
   logic [3:0]    nbits_reg;
   logic [DW-1:0] shift_reg;
   logic          pe_reg;
   logic          par_reg;
   logic [TW-1:0] stop_last_reg;
   logic          line_reg;
   logic          frame_done_reg;

   logic          fifo_empty;
   logic          fifo_full;
   logic          do_pop;
   logic          do_push;
   logic [DW-1:0] head;
   logic [DW-1:0] head_masked;
   logic [3:0]    nbits_cfg;
   logic          xor_cfg;
   logic          par_cfg;
   logic [TW-1:0] stop_last_cfg;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
   // Pop only on the POP tick and never from an empty FIFO (a flush can
   // empty it between IDLE->POP and the POP tick).
   assign do_pop     = enable && (state_reg == S_POP) && !fifo_empty;
   // A push into a full FIFO still fits when the head leaves in the same clk.
   assign do_push    = tf_push && !tx_reset && (!fifo_full || do_pop);
   assign head       = mem[rd_ptr_reg];

   // Lengths 5..7 saturate at the widest character the FIFO can hold.
   always_comb begin
      nbits_cfg = 4'(DW);
      if (cfg_len <= 3'd3)
         nbits_cfg = 4'(cfg_len) + 4'd5;
   end

   // Zero the bits above the active length so parity and shifting ignore them.
   for (genvar gi = 0; gi < DW; gi++) begin : g_mask
      assign head_masked[gi] = head[gi] & (4'(gi) < nbits_cfg);
   end

   assign xor_cfg = ^head_masked;
   // {ep,sp}: 00 odd, 10 even, 01 mark (1), 11 space (0).
   assign par_cfg = cfg_sp ? ~cfg_ep : (cfg_ep ? xor_cfg : ~xor_cfg);

   always_comb begin
      stop_last_cfg = OVS_LAST;
      if (cfg_stb)
         stop_last_cfg = (cfg_len == 3'd0) ? STOP15_LAST : STOP2_LAST;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= tf_data;
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i || tx_reset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         overrun_reg <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (tf_push && !do_push)
            overrun_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         state_reg      <= S_IDLE;
         tick_reg       <= '0;
         bit_reg        <= '0;
         nbits_reg      <= '0;
         shift_reg      <= '0;
         pe_reg         <= 1'b0;
         par_reg        <= 1'b0;
         stop_last_reg  <= '0;
         line_reg       <= 1'b1;
         frame_done_reg <= 1'b0;
      end else begin
         // frame_done is a single-clk strobe even when ticks are sparse.
         frame_done_reg <= 1'b0;
         if (state_reg > S_STOP) begin
            // Unused codes recover straight away, tick or not.
            state_reg <= S_IDLE;
            line_reg  <= 1'b1;
            tick_reg  <= '0;
         end else if (enable) begin
            unique case (state_reg)
               S_IDLE: begin
                  line_reg <= 1'b1;
                  if (!fifo_empty)
                     state_reg <= S_POP;
               end
               S_POP: begin
                  if (fifo_empty) begin
                     state_reg <= S_IDLE;
                  end else begin
                     shift_reg     <= head_masked;
                     nbits_reg     <= nbits_cfg;
                     pe_reg        <= cfg_pe;
                     par_reg       <= par_cfg;
                     stop_last_reg <= stop_last_cfg;
                     tick_reg      <= '0;
                     bit_reg       <= '0;
                     state_reg     <= S_START;
                     line_reg      <= 1'b0;
                  end
               end
               S_START: begin
                  if (tick_reg == OVS_LAST) begin
                     tick_reg  <= '0;
                     state_reg <= S_DATA;
                     line_reg  <= shift_reg[0];
                  end else begin
                     tick_reg <= tick_reg + TW'(1);
                  end
               end
               S_DATA: begin
                  if (tick_reg == OVS_LAST) begin
                     tick_reg <= '0;
                     if (bit_reg == nbits_reg - 4'd1) begin
                        if (pe_reg) begin
                           state_reg <= S_PARITY;
                           line_reg  <= par_reg;
                        end else begin
                           state_reg <= S_STOP;
                           line_reg  <= 1'b1;
                        end
                     end else begin
                        bit_reg   <= bit_reg + 4'd1;
                        shift_reg <= {1'b0, shift_reg[DW-1:1]};
                        line_reg  <= shift_reg[1];
                     end
                  end else begin
                     tick_reg <= tick_reg + TW'(1);
                  end
               end
               S_PARITY: begin
                  if (tick_reg == OVS_LAST) begin
                     tick_reg  <= '0;
                     state_reg <= S_STOP;
                     line_reg  <= 1'b1;
                  end else begin
                     tick_reg <= tick_reg + TW'(1);
                  end
               end
               S_STOP: begin
                  if (tick_reg == stop_last_reg) begin
                     tick_reg       <= '0;
                     state_reg      <= S_IDLE;
                     frame_done_reg <= 1'b1;
                     line_reg       <= 1'b1;
                  end else begin
                     tick_reg <= tick_reg + TW'(1);
                  end
               end
               default: begin
                  state_reg <= S_IDLE;
                  line_reg  <= 1'b1;
               end
            endcase
         end
      end
   end

   // Break overrides the line without stopping the FSM underneath.
   assign stx_pad_o  = cfg_bc ? 1'b0 : line_reg;
   assign tstate     = state_reg;
   assign tf_count   = count_reg;
   assign tf_full    = fifo_full;
   assign tf_overrun = overrun_reg;
   assign tx_empty   = fifo_empty && (state_reg == S_IDLE);
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: a waveform model (list of expected line
// level and state per enable tick) is built from the frame rules and
// compared tick by tick with what the transmitter drives.
module tb_uart_tx_param;
   localparam int DW    = 9;
   localparam int DEPTH = 16;
   localparam int OVS   = 16;

   logic       clk = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       enable = 1'b0;
   logic       tf_push = 1'b0;
   logic [8:0] tf_data = '0;
   logic       tx_reset = 1'b0;
   logic [2:0] cfg_len = 3'd3;
   logic       cfg_pe = 1'b0, cfg_ep = 1'b0, cfg_sp = 1'b0, cfg_stb = 1'b0, cfg_bc = 1'b0;
   logic       stx_pad_o;
   logic [2:0] tstate;
   logic [4:0] tf_count;
   logic       tf_full, tf_overrun, tx_empty, frame_done;

   uart_tx_param #(.DW(DW), .DEPTH(DEPTH), .OVS(OVS)) dut (
      .clk(clk), .wb_rst_i(wb_rst_i), .enable(enable), .tf_push(tf_push),
      .tf_data(tf_data), .tx_reset(tx_reset), .cfg_len(cfg_len),
      .cfg_pe(cfg_pe), .cfg_ep(cfg_ep), .cfg_sp(cfg_sp), .cfg_stb(cfg_stb),
      .cfg_bc(cfg_bc), .stx_pad_o(stx_pad_o), .tstate(tstate),
      .tf_count(tf_count), .tf_full(tf_full), .tf_overrun(tf_overrun),
      .tx_empty(tx_empty), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fd_count = 0;
   int fd_before = 0;
   int pre_ticks = 0;
   bit sparse = 1'b0;
   bit got_start;
   logic first_l;
   logic [2:0] first_s;
   logic end_fd, end_line;
   logic [2:0] end_state;

   logic       exp_line_q[$];
   logic [2:0] exp_state_q[$];
   logic       obs_line_q[$];
   logic [2:0] obs_state_q[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic clk_cycle(input bit en);
      @(negedge clk);
      enable = en;
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_count++;
   endtask

   task automatic push_word(input logic [8:0] d, input bit en);
      tf_push = 1'b1;
      tf_data = d;
      clk_cycle(en);
      tf_push = 1'b0;
   endtask

   // One enable tick (optionally preceded by idle clks), then sample.
   task automatic tick(output logic l, output logic [2:0] s);
      if (sparse) repeat ($urandom_range(0, 2)) clk_cycle(1'b0);
      clk_cycle(1'b1);
      l = stx_pad_o;
      s = tstate;
   endtask

   task automatic set_cfg(input logic [2:0] len, input logic pe, input logic ep,
                          input logic sp, input logic stb);
      cfg_len = len; cfg_pe = pe; cfg_ep = ep; cfg_sp = sp; cfg_stb = stb;
   endtask

   // Expected line/state for every tick from the first start tick to the
   // last stop tick.
   task automatic build_frame(input logic [8:0] d, input logic [2:0] len, input logic pe,
                              input logic ep, input logic sp, input logic stb);
      int nb, ones, stop_ticks;
      logic pb;
      exp_line_q.delete();
      exp_state_q.delete();
      nb = int'(len) + 5;
      if (nb > DW) nb = DW;
      ones = 0;
      repeat (OVS) begin exp_line_q.push_back(1'b0); exp_state_q.push_back(3'd2); end
      for (int b = 0; b < nb; b++) begin
         ones += int'(d[b]);
         repeat (OVS) begin exp_line_q.push_back(d[b]); exp_state_q.push_back(3'd3); end
      end
      if (pe) begin
         if (sp) pb = !ep;
         else if (ep) pb = (ones % 2 == 1);
         else pb = (ones % 2 == 0);
         repeat (OVS) begin exp_line_q.push_back(pb); exp_state_q.push_back(3'd4); end
      end
      if (!stb) stop_ticks = OVS;
      else if (nb == 5) stop_ticks = (3 * OVS) / 2;
      else stop_ticks = 2 * OVS;
      repeat (stop_ticks) begin exp_line_q.push_back(1'b1); exp_state_q.push_back(3'd5); end
   endtask

   task automatic wait_start();
      logic l;
      logic [2:0] s;
      pre_ticks = 0;
      tick(l, s);
      while (l !== 1'b0 && pre_ticks < 400) begin
         pre_ticks++;
         tick(l, s);
      end
      got_start = (l === 1'b0);
      first_l = l;
      first_s = s;
   endtask

   // Record a whole frame (length taken from the model) plus the tick after it.
   task automatic capture_frame(input bit scramble);
      logic l;
      logic [2:0] s;
      obs_line_q.delete();
      obs_state_q.delete();
      wait_start();
      if (!got_start) return;
      fd_before = fd_count;
      obs_line_q.push_back(first_l);
      obs_state_q.push_back(first_s);
      if (scramble) begin
         cfg_stb = !cfg_stb;
         cfg_len = 3'($urandom_range(0, 7));
         cfg_pe = 1'($urandom); cfg_ep = 1'($urandom); cfg_sp = 1'($urandom);
      end
      for (int i = 1; i < exp_line_q.size(); i++) begin
         tick(l, s);
         obs_line_q.push_back(l);
         obs_state_q.push_back(s);
      end
      tick(l, s);
      end_line = l;
      end_state = s;
      end_fd = frame_done;
   endtask

   task automatic send_frame(input logic [8:0] d, input bit scramble);
      build_frame(d, cfg_len, cfg_pe, cfg_ep, cfg_sp, cfg_stb);
      push_word(d, 1'b0);
      capture_frame(scramble);
   endtask

   function automatic int first_diff();
      if (obs_line_q.size() != exp_line_q.size()) return -2;
      for (int i = 0; i < exp_line_q.size(); i++)
         if (obs_line_q[i] !== exp_line_q[i] || obs_state_q[i] !== exp_state_q[i]) return i;
      return -1;
   endfunction

   function automatic string diff_str(input int idx);
      if (idx < 0)
         return $sformatf("captured %0d ticks, want %0d ticks", obs_line_q.size(), exp_line_q.size());
      return $sformatf("tick %0d got line=%b state=%0d, want line=%b state=%0d", idx,
                       obs_line_q[idx], obs_state_q[idx], exp_line_q[idx], exp_state_q[idx]);
   endfunction

   task automatic do_reset();
      wb_rst_i = 1'b1;
      clk_cycle(1'b0);
      wb_rst_i = 1'b0;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      clk_cycle(1'b0);
      clk_cycle(1'b0);
      checks++; if (stx_pad_o !== 1'b1) begin errors++; $display("FAIL reset stx_pad_o: got %b want 1", stx_pad_o); end
      checks++; if (tstate !== 3'd0) begin errors++; $display("FAIL reset tstate: got %0d want 0", tstate); end
      checks++; if (tf_count !== 5'd0) begin errors++; $display("FAIL reset tf_count: got %0d want 0", tf_count); end
      checks++; if (tf_full !== 1'b0 || tf_overrun !== 1'b0) begin errors++; $display("FAIL reset flags: got full=%b overrun=%b want 0/0", tf_full, tf_overrun); end
      checks++; if (frame_done !== 1'b0 || tx_empty !== 1'b1) begin errors++; $display("FAIL reset done/empty: got %b/%b want 0/1", frame_done, tx_empty); end
      wb_rst_i = 1'b0;
      clk_cycle(1'b0);
   endtask

   task automatic test_8n1();
      int idx;
      sparse = 1'b0;
      set_cfg(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(9'h055, 1'b0);
      idx = first_diff();
      checks++; if (idx != -1) begin errors++; $display("FAIL 8n1_55 waveform: %s", diff_str(idx)); end
      checks++; if (end_fd !== 1'b1 || fd_count - fd_before != 1) begin errors++; $display("FAIL 8n1_55 frame_done: got end=%b pulses=%0d want 1/1", end_fd, fd_count - fd_before); end
      checks++; if (tx_empty !== 1'b1 || end_state !== 3'd0) begin errors++; $display("FAIL 8n1_55 idle after: got tx_empty=%b tstate=%0d want 1/0", tx_empty, end_state); end
   endtask

   task automatic test_parity_7bit();
      int idx;
      for (int k = 0; k < 2; k++) begin
         set_cfg(3'd2, 1'b1, (k == 0), 1'b0, 1'b0);
         send_frame(9'h041, 1'b0);
         idx = first_diff();
         checks++; if (idx != -1) begin errors++; $display("FAIL parity7 ep=%0d waveform: %s", k == 0, diff_str(idx)); end
         checks++;
         if (obs_line_q.size() <= 136 || obs_line_q[136] !== (k != 0)) begin
            errors++; $display("FAIL parity7 ep=%0d parity bit: got %b want %b", k == 0,
                               (obs_line_q.size() > 136) ? obs_line_q[136] : 1'bx, k != 0);
         end
         checks++; if (end_fd !== 1'b1) begin errors++; $display("FAIL parity7 frame length: frame_done after 160 ticks got %b want 1", end_fd); end
      end
   endtask

   task automatic test_9bit_stick();
      int idx;
      set_cfg(3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      send_frame(9'h1A5, 1'b0);
      idx = first_diff();
      checks++; if (idx != -1) begin errors++; $display("FAIL 9bit_1a5 waveform: %s", diff_str(idx)); end
      checks++;
      if (obs_line_q.size() <= 168 || obs_line_q[168] !== 1'b1) begin
         errors++; $display("FAIL 9bit_1a5 parity bit: got %b want 1",
                            (obs_line_q.size() > 168) ? obs_line_q[168] : 1'bx);
      end
   endtask

   task automatic test_stop_len();
      int idx, stop_n;
      set_cfg(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(9'($urandom), 1'b1);   // stb toggled right after the start bit
      idx = first_diff();
      checks++; if (idx != -1) begin errors++; $display("FAIL stop1.5 waveform: %s", diff_str(idx)); end
      stop_n = 0;
      foreach (obs_state_q[i]) if (obs_state_q[i] === 3'd5 && obs_line_q[i] === 1'b1) stop_n++;
      checks++; if (stop_n != 24 || end_fd !== 1'b1) begin errors++; $display("FAIL stop1.5 length: got %0d stop ticks done=%b want 24/1", stop_n, end_fd); end
   endtask

   task automatic test_random();
      int idx;
      sparse = 1'b1;
      for (int k = 0; k < 12; k++) begin
         set_cfg(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         send_frame(9'($urandom), 1'b1);
         idx = first_diff();
         checks++; if (idx != -1) begin errors++; $display("FAIL random%0d waveform: %s", k, diff_str(idx)); end
         checks++; if (end_fd !== 1'b1 || fd_count - fd_before != 1) begin errors++; $display("FAIL random%0d frame_done: got end=%b pulses=%0d want 1/1", k, end_fd, fd_count - fd_before); end
      end
      sparse = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [8:0] w[3];
      int idx;
      set_cfg(3'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      foreach (w[i]) begin w[i] = 9'($urandom); push_word(w[i], 1'b0); end
      foreach (w[i]) begin
         build_frame(w[i], cfg_len, cfg_pe, cfg_ep, cfg_sp, cfg_stb);
         capture_frame(1'b0);
         idx = first_diff();
         checks++; if (idx != -1) begin errors++; $display("FAIL b2b%0d waveform: %s", i, diff_str(idx)); end
         checks++; if (pre_ticks != 1) begin errors++; $display("FAIL b2b%0d gap: got %0d high ticks before start want 1", i, pre_ticks); end
      end
      checks++; if (tx_empty !== 1'b1 || end_fd !== 1'b1) begin errors++; $display("FAIL b2b end: got tx_empty=%b done=%b want 1/1", tx_empty, end_fd); end
   endtask

   task automatic test_fifo_full();
      logic [8:0] w[17];
      logic l;
      logic [2:0] s;
      int idx, bad;
      set_cfg(3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      foreach (w[i]) begin w[i] = 9'($urandom); push_word(w[i], 1'b0); end
      checks++; if (tf_count !== 5'd16 || tf_full !== 1'b1 || tf_overrun !== 1'b1) begin errors++; $display("FAIL full17 flags: got count=%0d full=%b ovr=%b want 16/1/1", tf_count, tf_full, tf_overrun); end
      bad = -1;
      for (int i = 0; i < 16; i++) begin
         build_frame(w[i], cfg_len, cfg_pe, cfg_ep, cfg_sp, cfg_stb);
         capture_frame(1'b0);
         idx = first_diff();
         if (idx != -1 && bad < 0) bad = i;
      end
      checks++; if (bad >= 0) begin errors++; $display("FAIL full17 drain: frame %0d differs, got waveform mismatch want word %h", bad, w[bad]); end
      repeat (8) tick(l, s);
      checks++; if (tx_empty !== 1'b1 || tf_count !== 5'd0 || s !== 3'd0) begin errors++; $display("FAIL full17 17th absent: got tx_empty=%b count=%0d tstate=%0d want 1/0/0", tx_empty, tf_count, s); end
      // flush wins over a same-clk push
      foreach (w[i]) push_word(w[i], 1'b0);
      tx_reset = 1'b1;
      push_word(9'h0AA, 1'b0);
      tx_reset = 1'b0;
      checks++; if (tf_count !== 5'd0 || tf_full !== 1'b0 || tf_overrun !== 1'b0) begin errors++; $display("FAIL tx_reset: got count=%0d full=%b ovr=%b want 0/0/0", tf_count, tf_full, tf_overrun); end
      // push while full but popping in the same clk is accepted
      for (int i = 0; i < 16; i++) push_word(w[i], 1'b0);
      clk_cycle(1'b1);
      push_word(9'h133, 1'b1);
      checks++; if (tf_count !== 5'd16 || tf_overrun !== 1'b0 || tstate !== 3'd2) begin errors++; $display("FAIL push+pop full: got count=%0d ovr=%b tstate=%0d want 16/0/2", tf_count, tf_overrun, tstate); end
      do_reset();
   endtask

   task automatic test_reset_mid_frame();
      logic l;
      logic [2:0] s;
      int fd0, high;
      set_cfg(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      push_word(9'h0F0, 1'b0);
      push_word(9'h00F, 1'b0);
      wait_start();
      repeat (52) tick(l, s);   // middle of the third data bit
      checks++; if (s !== 3'd3 || tf_count !== 5'd1) begin errors++; $display("FAIL midreset pre: got tstate=%0d count=%0d want 3/1", s, tf_count); end
      wb_rst_i = 1'b1;
      clk_cycle(1'b0);
      wb_rst_i = 1'b0;
      checks++; if (stx_pad_o !== 1'b1 || tstate !== 3'd0 || tf_count !== 5'd0) begin errors++; $display("FAIL midreset: got stx=%b tstate=%0d count=%0d want 1/0/0", stx_pad_o, tstate, tf_count); end
      fd0 = fd_count;
      high = 0;
      repeat (40) begin tick(l, s); if (l === 1'b1 && s === 3'd0) high++; end
      checks++; if (high != 40 || fd_count != fd0) begin errors++; $display("FAIL midreset abort: got %0d idle ticks %0d pulses want 40/0", high, fd_count - fd0); end
   endtask

   task automatic test_break();
      logic l;
      logic [2:0] s;
      int fd0, bad, n;
      bit saw_data, saw_stop;
      set_cfg(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      push_word(9'h0C3, 1'b0);
      wait_start();
      repeat (10) tick(l, s);
      cfg_bc = 1'b1;
      #1;
      checks++; if (stx_pad_o !== 1'b0) begin errors++; $display("FAIL break immediate: got stx=%b want 0", stx_pad_o); end
      fd0 = fd_count; bad = 0; n = 0; saw_data = 0; saw_stop = 0;
      while (fd_count == fd0 && n < 400) begin
         tick(l, s);
         n++;
         if (l !== 1'b0) bad++;
         if (s === 3'd3) saw_data = 1;
         if (s === 3'd5) saw_stop = 1;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL break line: got %0d high ticks want 0", bad); end
      checks++; if (!saw_data || !saw_stop || fd_count != fd0 + 1) begin errors++; $display("FAIL break fsm: got data=%0d stop=%0d pulses=%0d want 1/1/1", saw_data, saw_stop, fd_count - fd0); end
      cfg_bc = 1'b0;
      #1;
      checks++; if (stx_pad_o !== 1'b1) begin errors++; $display("FAIL break release: got stx=%b want 1", stx_pad_o); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity_7bit();
      test_9bit_stick();
      test_stop_len();
      test_random();
      test_back_to_back();
      test_fifo_full();
      test_reset_mid_frame();
      test_break();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port wb_rst_i.
REQ-002 Parameter DW, default 9: maximum character width, legal range 8..9.
REQ-003 Parameter DEPTH, default 16: TX FIFO depth, power of two, 4..64.
REQ-004 Parameter OVS, default 16: enable ticks per bit, even, 8..32.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- enable  in  1  one-clk oversample tick
- tf_push  in  1  write tf_data into FIFO
- tf_data  in  DW  character, LSB first
- tx_reset  in  1  FIFO flush
- cfg_len  in  3  data bits = cfg_len+5; values 5..7 mean 9 bits (9 only if DW=9, else 8)
- cfg_pe  in  1  parity enable
- cfg_ep  in  1  even parity
- cfg_sp  in  1  stick parity
- cfg_stb  in  1  extra stop
- cfg_bc  in  1  break
- stx_pad_o  out  1  serial line
- tstate  out  3  FSM state
- tf_count  out  clog2(DEPTH)+1  FIFO occupancy
- tf_full  out  1  count==DEPTH
- tf_overrun  out  1  sticky push-when-full flag
- tx_empty  out  1  FIFO empty and tstate==IDLE
- frame_done  out  1  one-clk pulse at end of stop

Function
REQ-006 FSM states and encodings SHALL be: IDLE=0, POP=1, START=2, DATA=3, PARITY=4, STOP=5; codes 6 and 7 return to IDLE on the next clk.
REQ-007 All state, counter and output-register updates except FIFO push SHALL occur only in cycles with enable=1.
REQ-008 IDLE -> POP SHALL occur on an enable tick when tf_count!=0.
REQ-009 In POP, on the next enable tick the block SHALL perform the following in that one clk, then go to START:
- latch the head word and cfg_len/cfg_pe/cfg_ep/cfg_sp/cfg_stb;
- compute parity as the XOR of the active data bits;
- pop the FIFO.
REQ-010 Config changes mid-frame SHALL NOT affect the frame in flight.
REQ-011 START, each DATA bit and PARITY SHALL each last exactly OVS enable ticks; DATA SHALL shift LSB first through the latched length; bits above the length are ignored.
REQ-012 After the last data bit: if cfg_pe=0 go to STOP, else go to PARITY.
REQ-013 The parity bit value from {ep,sp} SHALL be: 00 -> ~xor, 10 -> xor, 01 -> 1, 11 -> 0.
REQ-014 STOP duration SHALL be:
- stb=0: OVS ticks;
- stb=1 with 5-bit length: 3*OVS/2 ticks;
- stb=1 otherwise: 2*OVS ticks.
REQ-015 At STOP end the block SHALL pulse frame_done for one clk and go to IDLE. Back-to-back frames SHALL take the POP tick between them.
REQ-016 Line values by state SHALL be registered:
- high in IDLE/POP/STOP;
- low in START;
- the data/parity bit in DATA/PARITY.
REQ-017 stx_pad_o SHALL equal 0 whenever cfg_bc=1, combinationally; the FSM continues to run underneath.
REQ-018 A push when not full SHALL write and increment tf_count.
REQ-019 A push when full SHALL be dropped and set tf_overrun.
REQ-020 Simultaneous push and pop SHALL leave tf_count unchanged and SHALL be accepted even when full.
REQ-021 A pop SHALL never occur when empty.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 tx_reset SHALL clear the pointers, tf_count and tf_overrun in the next clk, with priority over a same-cycle push. An already-latched frame SHALL complete.

Reset
REQ-024 On wb_rst_i=1 at a clk edge, independent of enable, the block SHALL set:
- tstate=IDLE, stx_pad_o=1 (unless cfg_bc=1);
- tf_count=0, tf_full=0, tf_overrun=0;
- frame_done=0, tx_empty=1;
- all counters and shift/parity registers to 0.
REQ-025 A reset mid-frame SHALL abort the frame immediately, with no stop bit emitted.

Verification
REQ-026 8N1, OVS=16, enable=1 every clk, push 0x55:
- start low for 16 ticks;
- bits 1,0,1,0,1,0,1,0, 16 ticks each;
- stop high for 16 ticks;
- frame_done once; tx_empty returns to 1.
REQ-027 7-bit, pe=1, ep=1, push 0x41 -> parity bit 0; with ep=0 -> parity bit 1; frame is 160 ticks plus POP.
REQ-028 9-bit (DW=9), pe=1, sp=1, ep=0, push 0x1A5 -> nine data bits 1,0,1,0,0,1,0,1,1, then parity 1.
REQ-029 5-bit, stb=1 -> stop high for exactly 24 ticks. With cfg_stb toggled mid-frame, the current frame keeps its latched value.
REQ-030 FIFO-full case, with enable held 0:
- 17 pushes -> tf_count=16, tf_full=1, tf_overrun=1, 17th word absent;
- tx_reset -> all three cleared.
REQ-031 Reset assertion and break during operation:
- wb_rst_i during the 3rd DATA bit -> next clk stx_pad_o=1, tstate=0, tf_count=0;
- cfg_bc=1 mid-frame -> line 0 while tstate keeps advancing.
